// File: rtl/rv32_instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into base-set instruction
// words and queues them, each tagged with an auto-incrementing byte address,
// in a 2-entry FIFO on a valid/ready output stream. Field sets that cannot be
// encoded become NOPs and are counted in a sticky error state.
module rv32_instr_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_cnt
);

  typedef enum logic [3:0] {
    K_R      = 4'd0,
    K_IALU   = 4'd1,
    K_LOAD   = 4'd2,
    K_JALR   = 4'd3,
    K_STORE  = 4'd4,
    K_BRANCH = 4'd5,
    K_LUI    = 4'd6,
    K_AUIPC  = 4'd7,
    K_JAL    = 4'd8
  } kind_e;

  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic [31:0]       push_word;
  logic              fits12;

  logic [31:0]       mem_data [2];
  logic [ADDR_W-1:0] mem_addr [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [ADDR_W-1:0] addr_cnt;
  logic              full;
  logic              push;
  logic              pop;

  // 12-bit signed immediate range check shared by I/LOAD/JALR/STORE.
  assign fits12 = (in_imm[31:11] == {21{in_imm[11]}});

  // Encode the presented field set and decide whether it is legal.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    enc_word  = NOP_WORD;
    enc_legal = 1'b0;
    case (in_kind)
      K_R: begin
        enc_word  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
        enc_legal = 1'b1;
      end
      K_IALU: begin
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
          enc_word  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_IMM};
          enc_legal = (in_imm[31:5] == 27'd0);
        end else begin
          enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
          enc_legal = fits12;
        end
      end
      K_LOAD: begin
        enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
        enc_legal = fits12;
      end
      K_JALR: begin
        enc_word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
        enc_legal = fits12;
      end
      K_STORE: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        enc_legal = fits12;
      end
      K_BRANCH: begin
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], OP_BRANCH};
        enc_legal = (in_imm[31:12] == {20{in_imm[31]}}) && !in_imm[0];
      end
      K_LUI: begin
        enc_word  = {in_imm[31:12], in_rd, OP_LUI};
        enc_legal = (in_imm[11:0] == 12'd0);
      end
      K_AUIPC: begin
        enc_word  = {in_imm[31:12], in_rd, OP_AUIPC};
        enc_legal = (in_imm[11:0] == 12'd0);
      end
      K_JAL: begin
        enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        enc_legal = (in_imm[31:20] == {12{in_imm[31]}}) && !in_imm[0];
      end
      default: begin
        enc_word  = NOP_WORD;
        enc_legal = 1'b0;
      end
    endcase
  end

  assign push_word = enc_legal ? enc_word : NOP_WORD;

  assign full      = (count == 2'd2);
  assign in_ready  = !full && !clr;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_data[rd_ptr];
  assign out_addr  = mem_addr[rd_ptr];

  // FIFO storage: write the encoded word and its address at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the two entries are reset because the head drives out_data and
    // out_addr directly and both must read zero straight out of reset.
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_addr[i] <= '0;
      end
    end else if (push) begin
      mem_data[wr_ptr] <= push_word;
      mem_addr[wr_ptr] <= addr_cnt;
    end
  end

  // FIFO pointers and occupancy; clr drops every queued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Address counter and sticky error bookkeeping, advanced on each accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt <= BASE;
      err      <= 1'b0;
      err_cnt  <= 8'd0;
    end else if (clr) begin
      addr_cnt <= BASE;
      err      <= 1'b0;
      err_cnt  <= 8'd0;
    end else if (push) begin
      addr_cnt <= addr_cnt + ADDR_W'(4);
      if (!enc_legal) begin
        err <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule
